regfile_nport: RTL
==================

Name: regfile_nport

Overview:
- Parametrised successor to the 2x4-bit register bank: NREGS x DATASIZE register file with two registered read ports and one write port, all driven by a small opcode.
- Adds a multi-cycle sweep-clear state machine with a busy flag.
- Sits between the instruction decoder and the ALU operand inputs of the prototype processor.

Parameters:
- DATASIZE, 8, width of each register and of data_in/out_A/out_B
- ADDRW, 2, register address width; NREGS = 2**ADDRW registers

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- main_enable  input  1  command qualifier; op is sampled only when 1
- op  input  3  opcode (see Behaviour)
- addr_a  input  ADDRW  read port A register index
- addr_b  input  ADDRW  read port B register index
- addr_w  input  ADDRW  write register index
- data_in  input  DATASIZE  write data
- out_A  output  DATASIZE  registered read data, port A
- out_B  output  DATASIZE  registered read data, port B
- busy  output  1  high while the sweep-clear is running; commands are ignored

Behaviour:
- Reset (async, any time, including mid-sweep):
  - all registers = 0; out_A = out_B = 0; busy = 0; FSM -> IDLE; sweep counter = 0.
- Command is accepted on a clk edge when main_enable=1 and busy=0. Otherwise registers, out_A and out_B hold.
- Opcodes:
  - 0 RW: out_A <= reg[addr_a]; out_B <= reg[addr_b]; reg[addr_w] <= data_in.
  - 1 RD: out_A/out_B load as in RW; no write.
  - 2 WR: reg[addr_w] <= data_in; outputs hold.
  - 3 CLR: start the sweep; FSM IDLE -> CLEAR.
  - 4 MOV: reg[addr_w] <= reg[addr_a]; outputs hold.
  - 5..7 NOP: no state change.
- Read latency: 1 clk. Data appears on out_A/out_B the edge after the command.
- Same-edge read/write to the same index: read returns the pre-write value unless BYPASS_EN (see below).
- addr_a == addr_b is legal; both ports return the same value.
- MOV with addr_a == addr_w: no change.
- FSM states: IDLE, CLEAR.
  - IDLE: busy=0; CLR -> CLEAR with counter=0.
  - CLEAR: busy=1. Each edge: reg[counter] <= 0, counter++. After writing index NREGS-1, -> IDLE. Counter wraps to 0.
  - CLR therefore occupies exactly NREGS cycles: busy is high for NREGS edges after the CLR edge, then low.
  - out_A/out_B hold their values throughout CLEAR.
  - Commands presented while busy=1 are dropped, not queued.
- busy is a registered output, asserted on the edge that accepts CLR.
- All widths are exact; there is no arithmetic beyond the ADDRW-bit sweep counter.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: a read in RW whose addr_a/addr_b equals addr_w returns data_in (write-first forwarding) on the corresponding port.
- Undefined: such a read returns the old register contents (read-first).
- MOV and the sweep are unaffected either way.

Test Plan:
- Assert rst mid-cycle after writing reg2=0x5A -> out_A=out_B=0 and busy=0 immediately (asynchronous); RD a=2 -> out_A=0x00.
- WR w=1 d=0x3C; WR w=3 d=0xA5; RD a=1 b=3 -> next edge out_A=0x3C, out_B=0xA5.
- Preload reg0=0x11; RW a=0 b=0 w=0 d=0x77 -> out_A=out_B=0x11 without the macro, 0x77 with REGFILE_BYPASS_EN. Reg0=0x77 afterwards in both cases.
- Fill regs with 0x01..0x04; CLR -> busy high for exactly 4 edges. A WR w=2 d=0xFF issued while busy is dropped. After busy falls, RD of all indices returns 0.
- CLR, then assert rst after 2 sweep edges -> busy=0, all regs 0, FSM IDLE. A following WR/RD works on the next edge.
- reg1=0x42; MOV a=1 w=3 -> reg3=0x42 and outputs unchanged. main_enable=0 with op=WR -> no register change.

Source files
------------

// File: rtl/regfile_nport.sv
// NREGS x DATASIZE register file: two registered read ports, one write port, opcode-driven,
// with a multi-cycle sweep-clear. Define REGFILE_BYPASS_EN for write-first forwarding on RW.
module regfile_nport #(
    parameter int DATASIZE = 8,
    parameter int ADDRW    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                main_enable,
    input  logic [2:0]          op,
    input  logic [ADDRW-1:0]    addr_a,
    input  logic [ADDRW-1:0]    addr_b,
    input  logic [ADDRW-1:0]    addr_w,
    input  logic [DATASIZE-1:0] data_in,
    output logic [DATASIZE-1:0] out_A,
    output logic [DATASIZE-1:0] out_B,
    output logic                busy
);
    localparam int NREGS = 2 ** ADDRW;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef enum logic [2:0] {
        OP_RW  = 3'd0,
        OP_RD  = 3'd1,
        OP_WR  = 3'd2,
        OP_CLR = 3'd3,
        OP_MOV = 3'd4
    } op_t;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    state_t                state;
    logic [ADDRW-1:0]      sweep_cnt;
    logic [DATASIZE-1:0]   regs [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the array is reset element by element because a reset must leave every
            // register at zero; this keeps it in flops rather than a RAM macro.
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            out_A     <= '0;
            out_B     <= '0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
            sweep_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments make every read below see pre-edge register
            // contents, which gives read-first behaviour on same-index RW for free.
            case (state)
                ST_IDLE: begin
                    if (main_enable) begin
                        case (op)
                            OP_RW: begin
                                out_A <= (BYPASS && addr_a == addr_w) ? data_in : regs[addr_a];
                                out_B <= (BYPASS && addr_b == addr_w) ? data_in : regs[addr_b];
                                regs[addr_w] <= data_in;
                            end
                            OP_RD: begin
                                out_A <= regs[addr_a];
                                out_B <= regs[addr_b];
                            end
                            OP_WR: begin
                                regs[addr_w] <= data_in;
                            end
                            OP_CLR: begin
                                state     <= ST_CLEAR;
                                busy      <= 1'b1;
                                sweep_cnt <= '0;
                            end
                            OP_MOV: begin
                                regs[addr_w] <= regs[addr_a];
                            end
                            default: ;
                        endcase
                    end
                end
                ST_CLEAR: begin
                    // Commands are dropped while sweeping; outputs hold.
                    regs[sweep_cnt] <= '0;
                    sweep_cnt       <= sweep_cnt + 1'b1;
                    if (sweep_cnt == {ADDRW{1'b1}}) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
